// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target.
package spi_pkg;

  localparam int unsigned SPI_BYTE_BITS = 8;
  localparam int unsigned SPI_CNT_W     = 3;

  typedef logic [SPI_BYTE_BITS-1:0] spi_byte_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_target_rx_fifo.sv
// Receive FIFO: circular buffer, pointers carry an extra wrap bit for full/empty.
module spi_target_rx_fifo
  import spi_pkg::*;
#(
  parameter int unsigned LGDEPTH = 2
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      push,
  input  spi_byte_t push_data,
  input  logic      pop,
  output spi_byte_t head_c,
  output logic      empty_c,
  output logic      full_c
);

  localparam int unsigned DEPTH = 1 << LGDEPTH;
  localparam int unsigned PTR_W = LGDEPTH + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  spi_byte_t        mem [DEPTH];

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[LGDEPTH] != rd_ptr[LGDEPTH]) &&
                   (wr_ptr[LGDEPTH-1:0] == rd_ptr[LGDEPTH-1:0]);
  assign head_c  = mem[rd_ptr[LGDEPTH-1:0]];

  // Storage and pointer update; push and pop may coincide in any state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[LGDEPTH-1:0]] <= push_data;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled pins, MSB-first rx/tx byte streams.
// Optional receive FIFO selected by SPI_TARGET_RX_FIFO_EN.
module spi_target
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter spi_byte_t   FILL_BYTE   = 8'hff,
  parameter int unsigned RX_LGDEPTH  = 2
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      spi_clk,
  input  logic      spi_mosi,
  input  logic      spi_csn,
  output logic      spi_miso,
  output logic      rx_valid,
  output spi_byte_t rx_data,
  input  logic      rx_ready,
  input  logic      tx_valid,
  input  spi_byte_t tx_data,
  output logic      tx_ready,
  output logic      rx_overrun,
  output logic      tx_underrun
);

  if (SYNC_STAGES < 2 || RX_LGDEPTH < 1) begin : g_param_check
    $error("spi_target: SYNC_STAGES must be >= 2 and RX_LGDEPTH >= 1");
  end

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] csn_sync;
  logic                   sclk_d;
  logic                   csn_d;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   csn_s;
  logic                   rise_c;
  logic                   fall_c;
  logic                   csn_fall_c;

  spi_state_t             state;
  spi_state_t             state_d;
  logic [SPI_CNT_W-1:0]   bit_cnt;
  logic [6:0]             rx_shift;
  logic [6:0]             tx_rest;
  logic                   byte_end;
  spi_byte_t              hold;

  logic                   start_c;
  logic                   abort_c;
  logic                   rx_shift_en_c;
  logic                   deliver_c;
  logic                   load_c;
  logic                   tx_shift_en_c;
  spi_byte_t              rx_byte_c;

  // Pin synchronisers plus one delayed copy of sclk/csn for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      csn_sync  <= '1;
      sclk_d    <= 1'b0;
      csn_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      sclk_d    <= sclk_s;
      csn_d     <= csn_s;
    end
  end

  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign csn_s      = csn_sync[SYNC_STAGES-1];
  assign rise_c     = sclk_s && !sclk_d;
  assign fall_c     = !sclk_s && sclk_d;
  assign csn_fall_c = !csn_s && csn_d;
  assign rx_byte_c  = {rx_shift, mosi_s};

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  // Next state and per-cycle datapath strobes.
  always_comb begin
    state_d       = state;
    start_c       = 1'b0;
    abort_c       = 1'b0;
    rx_shift_en_c = 1'b0;
    deliver_c     = 1'b0;
    load_c        = 1'b0;
    tx_shift_en_c = 1'b0;
    case (state)
      IDLE: begin
        if (csn_fall_c) begin
          state_d = ACTIVE;
          start_c = 1'b1;
          load_c  = 1'b1;
        end
      end
      ACTIVE: begin
        if (csn_s) begin
          state_d = IDLE;
          abort_c = 1'b1;
        end else if (rise_c) begin
          rx_shift_en_c = 1'b1;
          deliver_c     = (bit_cnt == SPI_CNT_W'(7));
        end else if (fall_c) begin
          load_c        = byte_end;
          tx_shift_en_c = !byte_end;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit counter and receive shifter; byte_end arms the reload on the next fall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      byte_end <= 1'b0;
    end else begin
      if (start_c || abort_c) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
        byte_end <= 1'b0;
      end else if (rx_shift_en_c) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
        bit_cnt  <= bit_cnt + SPI_CNT_W'(1);
        if (deliver_c) byte_end <= 1'b1;
      end else if (load_c) begin
        byte_end <= 1'b0;
      end
    end
  end

  // Transmit holding register, MISO shifter and underrun pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold        <= '0;
      tx_ready    <= 1'b1;
      tx_rest     <= '0;
      spi_miso    <= 1'b1;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (load_c) begin
        if (!tx_ready) begin
          tx_rest  <= hold[6:0];
          spi_miso <= hold[7];
          tx_ready <= 1'b1;
        end else begin
          tx_rest     <= FILL_BYTE[6:0];
          spi_miso    <= FILL_BYTE[7];
          tx_underrun <= 1'b1;
        end
      end else if (tx_shift_en_c) begin
        tx_rest  <= {tx_rest[5:0], 1'b0};
        spi_miso <= tx_rest[6];
      end else if (state == IDLE || abort_c) begin
        spi_miso <= 1'b1;
      end
      // A handshake only happens while empty, so it never collides with a hold load.
      if (tx_valid && tx_ready) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end
    end
  end

`ifdef SPI_TARGET_RX_FIFO_EN
  logic      fifo_empty_c;
  logic      fifo_full_c;
  logic      fifo_pop_c;
  logic      fifo_push_c;
  spi_byte_t fifo_head_c;

  assign fifo_pop_c  = rx_ready && !fifo_empty_c;
  assign fifo_push_c = deliver_c && (!fifo_full_c || fifo_pop_c);
  assign rx_valid    = !fifo_empty_c;
  assign rx_data     = fifo_head_c;

  spi_target_rx_fifo #(
    .LGDEPTH (RX_LGDEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push_c),
    .push_data (rx_byte_c),
    .pop       (fifo_pop_c),
    .head_c    (fifo_head_c),
    .empty_c   (fifo_empty_c),
    .full_c    (fifo_full_c)
  );

  // Overrun when a byte arrives at a full FIFO that is not draining this cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rx_overrun <= 1'b0;
    else         rx_overrun <= deliver_c && fifo_full_c && !fifo_pop_c;
  end
`else
  // Single receive register: replace on same-cycle consume, drop otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (deliver_c) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_byte_c;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_target.sv
// Directed self-checking bench for spi_target acting as an SPI mode-0 controller.
module tb_spi_target;

  localparam int H = 6;

  logic       clk = 1'b0;
  logic       resetn;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_csn;
  logic       spi_miso;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_overrun;
  logic       tx_underrun;

  int         checks   = 0;
  int         failures = 0;
  int         ovr_cnt  = 0;
  int         und_cnt  = 0;
  logic [7:0] rxq[$];

  spi_target dut (
    .clk         (clk),
    .resetn      (resetn),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_csn     (spi_csn),
    .spi_miso    (spi_miso),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .rx_overrun  (rx_overrun),
    .tx_underrun (tx_underrun)
  );

  always #5 clk = ~clk;

  // Record rx handshakes and pulses on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (resetn) begin
      if (rx_valid && rx_ready) rxq.push_back(rx_data);
      if (rx_overrun) ovr_cnt++;
      if (tx_underrun) und_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rxq.delete();
    ovr_cnt = 0;
    und_cnt = 0;
  endtask

  task automatic csn_low();
    spi_csn = 1'b0;
    step(H);
  endtask

  task automatic csn_high();
    spi_csn = 1'b1;
    step(H);
  endtask

  task automatic sclk_bit(input logic b, output logic m);
    spi_mosi = b;
    step(H);
    m = spi_miso;
    spi_clk = 1'b1;
    step(H);
    spi_clk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] b, output logic [7:0] m);
    logic mb;
    for (int i = 7; i >= 0; i--) begin
      sclk_bit(b[i], mb);
      m[i] = mb;
    end
    step(H);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    step(5);
    rx_ready = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    spi_csn  = 1'b1;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    step(3);
    checks++; if (spi_miso !== 1'b1) begin failures++; $display("FAIL reset_miso got=%b want=1", spi_miso); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b want=1", tx_ready); end
    checks++; if ({rx_overrun, tx_underrun} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b want=00", {rx_overrun, tx_underrun}); end
    resetn = 1'b1;
    step(4);
  endtask

  task automatic test_fill();
    logic [7:0] m;
    clear_mon();
    csn_low();
    checks++; if (und_cnt !== 1) begin failures++; $display("FAIL fill_underrun_at_csn got=%0d want=1", und_cnt); end
    xfer(8'hA5, m);
    csn_high();
    checks++; if (m !== 8'hFF) begin failures++; $display("FAIL fill_miso got=%h want=ff", m); end
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL fill_rx_valid got=%b want=1", rx_valid); end
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL fill_rx_data got=%h want=a5", rx_data); end
    drain();
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL fill_rx_pop got=%b want=0", rx_valid); end
  endtask

  task automatic test_preload();
    logic [7:0] m;
    clear_mon();
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL preload_held got=%b want=0", tx_ready); end
    csn_low();
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL preload_tx_ready got=%b want=1", tx_ready); end
    checks++; if (und_cnt !== 0) begin failures++; $display("FAIL preload_no_underrun got=%0d want=0", und_cnt); end
    xfer(8'h00, m);
    csn_high();
    checks++; if (m !== 8'h3C) begin failures++; $display("FAIL preload_miso got=%h want=3c", m); end
    checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b1) begin failures++; $display("FAIL preload_rx got=%h/%b want=00/1", rx_data, rx_valid); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] m;
    clear_mon();
    rx_ready = 1'b1;
    csn_low();
    xfer(8'h12, m);
    xfer(8'h34, m);
    csn_high();
    rx_ready = 1'b0;
    step(1);
    checks++; if (rxq.size() !== 2) begin failures++; $display("FAIL b2b_count got=%0d want=2", rxq.size()); end
    if (rxq.size() >= 2) begin
      checks++; if (rxq[0] !== 8'h12) begin failures++; $display("FAIL b2b_first got=%h want=12", rxq[0]); end
      checks++; if (rxq[1] !== 8'h34) begin failures++; $display("FAIL b2b_second got=%h want=34", rxq[1]); end
    end
    checks++; if (ovr_cnt !== 0) begin failures++; $display("FAIL b2b_overrun got=%0d want=0", ovr_cnt); end
  endtask

  task automatic test_overrun();
    logic [7:0] m;
    clear_mon();
    rx_ready = 1'b0;
    csn_low();
    xfer(8'h01, m);
    xfer(8'h02, m);
    xfer(8'h03, m);
    csn_high();
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h01) begin failures++; $display("FAIL ovr_head got=%h/%b want=01/1", rx_data, rx_valid); end
`ifdef SPI_TARGET_RX_FIFO_EN
    checks++; if (ovr_cnt !== 0) begin failures++; $display("FAIL ovr_count got=%0d want=0", ovr_cnt); end
    drain();
    checks++; if (rxq.size() !== 3) begin failures++; $display("FAIL ovr_queued got=%0d want=3", rxq.size()); end
    if (rxq.size() == 3) begin
      checks++; if ({rxq[0], rxq[1], rxq[2]} !== 24'h010203) begin failures++; $display("FAIL ovr_order got=%h%h%h want=010203", rxq[0], rxq[1], rxq[2]); end
    end
`else
    checks++; if (ovr_cnt !== 2) begin failures++; $display("FAIL ovr_count got=%0d want=2", ovr_cnt); end
    drain();
    checks++; if (rxq.size() !== 1) begin failures++; $display("FAIL ovr_kept got=%0d want=1", rxq.size()); end
`endif
  endtask

  task automatic test_abort();
    logic [7:0] m;
    logic       mb;
    clear_mon();
    rx_ready = 1'b1;
    csn_low();
    for (int i = 0; i < 5; i++) sclk_bit(1'b1, mb);
    step(H);
    csn_high();
    checks++; if (spi_miso !== 1'b1) begin failures++; $display("FAIL abort_miso got=%b want=1", spi_miso); end
    checks++; if (rxq.size() !== 0) begin failures++; $display("FAIL abort_partial got=%0d want=0", rxq.size()); end
    csn_low();
    xfer(8'h5A, m);
    csn_high();
    rx_ready = 1'b0;
    step(1);
    checks++; if (rxq.size() !== 1) begin failures++; $display("FAIL abort_count got=%0d want=1", rxq.size()); end
    if (rxq.size() == 1) begin
      checks++; if (rxq[0] !== 8'h5A) begin failures++; $display("FAIL abort_data got=%h want=5a", rxq[0]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] m;
    logic       mb;
    clear_mon();
    csn_low();
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) sclk_bit(1'b1, mb);
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL mid_held got=%b want=0", tx_ready); end
    resetn = 1'b0;
    step(2);
    checks++; if (spi_miso !== 1'b1 || rx_valid !== 1'b0 || tx_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ctrl got=%b%b%b want=101", spi_miso, rx_valid, tx_ready); end
    checks++; if (rx_data !== 8'h00 || rx_overrun !== 1'b0 || tx_underrun !== 1'b0) begin failures++; $display("FAIL mid_reset_data got=%h %b%b want=00 00", rx_data, rx_overrun, tx_underrun); end
    spi_csn = 1'b1;
    step(2);
    resetn = 1'b1;
    step(H);
    csn_low();
    xfer(8'hC3, m);
    csn_high();
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hC3) begin failures++; $display("FAIL mid_rx got=%h/%b want=c3/1", rx_data, rx_valid); end
    checks++; if (m !== 8'hFF) begin failures++; $display("FAIL mid_miso got=%h want=ff", m); end
    drain();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_preload();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
